// File: rtl/jk_mod_counter.sv
//------------------------------------------------------------------------------
// jk_mod_counter
//
// Synchronous modulo-MODULUS up/down counter. Each state bit is updated
// through the JK next-state equation Q+ = (J & ~Q) | (~K & Q). The J/K
// excitation vector is exported so a downstream JK storage stage can use it.
//
// Parameters:
//   WIDTH    number of count bits (2**WIDTH >= MODULUS)
//   MODULUS  count range is 0 .. MODULUS-1 (2 .. 2**WIDTH)
//
// Ports:
//   Clk    in   1      rising-edge clock
//   Reset  in   1      synchronous active-high reset (highest priority)
//   En     in   1      count enable
//   Up     in   1      direction, 1 = increment, 0 = decrement
//   Load   in   1      synchronous parallel load (values above MODULUS-1 clamp)
//   D      in   WIDTH  parallel load value
//   Q      out  WIDTH  registered count
//   Q_bar  out  WIDTH  ~Q
//   J      out  WIDTH  per-bit J excitation for the current cycle
//   K      out  WIDTH  per-bit K excitation for the current cycle
//   TC     out  1      terminal count (combinational)
//   Wrap   out  1      registered copy of TC, one cycle late
//
// Build option:
//   JK_COUNTER_SATURATE_EN  when defined the counter saturates at 0 and
//                           MODULUS-1 instead of wrapping; Wrap then acts as
//                           a saturation flag with the same timing.
//------------------------------------------------------------------------------
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             TC,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_CNT = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_CNT  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Clamp a load value into the legal range so unused codes stay unreachable.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
    if (d > MAX_CNT) begin
      return MAX_CNT;
    end else begin
      return d;
    end
  endfunction

  // Modulo step in the requested direction.
  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] q,
                                                  input logic             up);
    logic [WIDTH-1:0] n;
    case (up)
      1'b1:    n = (q == MAX_CNT)  ? ZERO_CNT : q + ONE_CNT;
      1'b0:    n = (q == ZERO_CNT) ? MAX_CNT  : q - ONE_CNT;
      default: n = q;
    endcase
    return n;
  endfunction

  // Per-bit JK flip-flop characteristic equation.
  function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] q,
                                               input logic [WIDTH-1:0] j,
                                               input logic [WIDTH-1:0] k);
    return (j & ~q) | (~k & q);
  endfunction

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic             count_s;
  logic             at_max_s;
  logic             at_zero_s;
  logic             tc_s;
  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;

  // Terminal-count detection; only meaningful while actually counting.
  always_comb begin
    count_s   = En & ~Load;
    at_max_s  = (q_r == MAX_CNT);
    at_zero_s = (q_r == ZERO_CNT);
    tc_s      = count_s & ((Up & at_max_s) | (~Up & at_zero_s));
  end

  // Target count and the J/K excitation that reaches it; bits that must
  // toggle get J = K = 1, all other bits get J = K = 0 (hold).
  always_comb begin
    next_s = q_r;
    if (count_s) begin
`ifdef JK_COUNTER_SATURATE_EN
      if (tc_s) begin
        next_s = q_r;
      end else begin
        next_s = step_count(q_r, Up);
      end
`else
      next_s = step_count(q_r, Up);
`endif
    end else begin
      next_s = q_r;
    end
    j_s = q_r ^ next_s;
    k_s = q_r ^ next_s;
  end

  // Count register: reset, direct load, otherwise JK update (J = K = 0 holds).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_r    <= ZERO_CNT;
      wrap_r <= 1'b0;
    end else if (Load) begin
      q_r    <= clamp_load(D);
      wrap_r <= 1'b0;
    end else begin
      q_r    <= jk_next(q_r, j_s, k_s);
      wrap_r <= tc_s;
    end
  end

  assign Q     = q_r;
  assign Q_bar = ~q_r;
  assign J     = j_s;
  assign K     = k_s;
  assign TC    = tc_s;
  assign Wrap  = wrap_r;

endmodule

// File: tb/tb_jk_mod_counter.sv
module tb_jk_mod_counter;

  logic       Clk = 1'b0;
  logic       Reset, En, Up, Load;
  logic [3:0] D;
  logic [3:0] Q, Q_bar, J, K;
  logic       TC, Wrap;

  int passed = 0;
  int total  = 0;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load), .D(D),
    .Q(Q), .Q_bar(Q_bar), .J(J), .K(K), .TC(TC), .Wrap(Wrap)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int e;
    // Reset wins over Load/En/Up
    Reset = 1'b1; En = 1'b1; Up = 1'b1; Load = 1'b1; D = 4'd7;
    step();
    chk("rst_q", Q, 4'd0);
    chk("rst_qbar", Q_bar, 4'hF);
    chk("rst_wrap", Wrap, 1'b0);
    chk("rst_tc_load", TC, 1'b0);

    // Count up 12 edges from 0
    Reset = 1'b0; Load = 1'b0; En = 1'b1; Up = 1'b1;
    #1;
    chk("up0_j", J, 4'b0001);
    chk("up0_k", K, 4'b0001);
    for (int i = 1; i <= 12; i++) begin
      step();
      e = i % 10;
      chk($sformatf("up_q%0d", i), Q, e);
      chk($sformatf("up_tc%0d", i), TC, (e == 9));
      chk($sformatf("up_wrap%0d", i), Wrap, (e == 0));
      if (e == 9) begin
        chk("up9_j", J, 4'b1001);
        chk("up9_k", K, 4'b1001);
      end
      if (e == 5) begin
        chk("up5_j", J, 4'b0011);
        chk("up5_k", K, 4'b0011);
      end
    end

    // Clamped load, TC suppressed while loading
    Load = 1'b1; D = 4'd13;
    #1;
    chk("load_tc", TC, 1'b0);
    chk("load_j", J, 4'b0000);
    step();
    chk("load13_q", Q, 4'd9);
    chk("load13_wrap", Wrap, 1'b0);

    // Count down 11 edges from 9
    Load = 1'b0; Up = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      step();
      e = (19 - i) % 10;
      chk($sformatf("dn_q%0d", i), Q, e);
      chk($sformatf("dn_tc%0d", i), TC, (e == 0));
      chk($sformatf("dn_wrap%0d", i), Wrap, (i == 10));
      if (e == 0) begin
        chk("dn0_j", J, 4'b1001);
        chk("dn0_k", K, 4'b1001);
      end
    end

    // Load boundaries
    Load = 1'b1; D = 4'd10;
    step();
    chk("load10_q", Q, 4'd9);
    D = 4'd5;
    step();
    chk("load5_q", Q, 4'd5);

    // Hold with Up toggling
    Load = 1'b0; En = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Up = i[0];
      #1;
      chk("hold_j", J, 4'b0000);
      chk("hold_k", K, 4'b0000);
      chk("hold_tc", TC, 1'b0);
      step();
      chk("hold_q", Q, 4'd5);
      chk("hold_wrap", Wrap, 1'b0);
    end

    // Reset mid-count together with Load
    Load = 1'b1; D = 4'd3;
    step();
    chk("load3_q", Q, 4'd3);
    Load = 1'b0; En = 1'b1; Up = 1'b1;
    Reset = 1'b1; Load = 1'b1; D = 4'd7;
    step();
    chk("midrst_q", Q, 4'd0);
    Reset = 1'b0; Load = 1'b0;
    step();
    chk("resume1_q", Q, 4'd1);
    step();
    chk("resume2_q", Q, 4'd2);
    // Direction change takes effect immediately
    Up = 1'b0;
    step();
    chk("dirchg_q", Q, 4'd1);

`ifdef JK_COUNTER_SATURATE_EN
    Load = 1'b1; D = 4'd9;
    step();
    Load = 1'b0; En = 1'b1; Up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sat_j", J, 4'b0000);
      chk("sat_k", K, 4'b0000);
      step();
      chk("sat_q", Q, 4'd9);
      chk("sat_tc", TC, 1'b1);
      chk("sat_wrap", Wrap, 1'b1);
    end
    Up = 1'b0;
    step();
    chk("sat_down_q", Q, 4'd8);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter whose state bits are updated by JK excitation logic. Each bit uses the JK next-state equation Q+ = (J & ~Q) | (~K & Q).
- Sits directly upstream of the JKFlipFlop storage stage. It produces the per-bit J/K excitation vector and the registered count, and is the next building block after the single JK cell.
- Used as the counting and sequencing core for the lab's divider and timer exercises.

Parameters:
- WIDTH, 4, number of count bits. Must satisfy 2^WIDTH >= MODULUS.
- MODULUS, 10, count range is 0..MODULUS-1. Legal values are 2..2^WIDTH.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset; one clock, synchronous, active-high.
- En  input  1  count enable.
- Up  input  1  direction: 1 = increment, 0 = decrement.
- Load  input  1  synchronous parallel load.
- D  input  WIDTH  parallel load value.
- Q  output  WIDTH  registered count.
- Q_bar  output  WIDTH  bitwise ~Q, combinational from Q.
- J  output  WIDTH  per-bit J excitation for the current cycle (combinational).
- K  output  WIDTH  per-bit K excitation for the current cycle (combinational).
- TC  output  1  terminal count, combinational.
- Wrap  output  1  registered one-cycle pulse.

Behaviour:
- All state changes occur on the rising edge of Clk only.
- Priority per edge: Reset > Load > En > hold.
- Reset = 1:
  - Q <= 0, Wrap <= 0.
  - Q_bar = all ones; TC reflects Q = 0.
  - Takes effect at the next edge regardless of En, Load or Up.
  - Reset asserted mid-count discards the count. There is no recovery state.
- Load = 1 (Reset = 0):
  - Q <= D if D <= MODULUS-1; otherwise Q <= MODULUS-1 (clamp).
  - Wrap <= 0.
  - En and Up are ignored.
- En = 1, Load = 0: next count N is
  - Up = 1: N = (Q == MODULUS-1) ? 0 : Q+1.
  - Up = 0: N = (Q == 0) ? MODULUS-1 : Q-1.
- Excitation vector (combinational, every cycle):
  - Bits that must change: J = K = 1.
  - Bits that stay 0: J = 0, K = 0.
  - Bits that stay 1: J = 0, K = 0.
  - Q is updated only via the JK equation applied per bit, never by direct assignment of N.
  - When En = 0 or Load = 1, J = K = 0 (hold excitation). The Load path writes Q directly.
- Hold (En = 0, Load = 0, Reset = 0): Q unchanged, Wrap <= 0.
- TC = En & ~Load & ((Up & Q == MODULUS-1) | (~Up & Q == 0)).
- Wrap <= TC on each edge where Reset = 0. It is high for exactly the one cycle after the wrap edge.
- Latency:
  - Q changes one edge after En, Load or Reset is sampled.
  - TC, J and K follow their inputs in the same cycle.
  - Wrap lags TC by one cycle.
- Direction change takes effect on the edge at which the new Up value is sampled. No dead cycle.
- Non-power-of-two MODULUS: the unused codes (MODULUS..2^WIDTH-1) are unreachable through count or load.

Optional Feature:
- Macro: JK_COUNTER_SATURATE_EN.
- Defined:
  - Counter saturates instead of wrapping. Up at MODULUS-1 holds MODULUS-1; down at 0 holds 0.
  - J = K = 0 at saturation.
  - TC still asserts at the limit.
  - Wrap is renamed in function to a saturation flag: Wrap <= TC (same timing) but Q does not change.
- Undefined: modulo wrap exactly as in Behaviour.

Test Plan:
- Reset = 1 for 1 edge with En = 1, Up = 1, Load = 1, D = 4'd7 -> Q = 0, Q_bar = 4'hF, Wrap = 0.
- Reset = 0, En = 1, Up = 1 for 12 edges from 0 -> Q = 1..9, 0, 1, 2. TC high while Q = 9. Wrap high the cycle Q = 0. J = K = 4'b1001 when Q = 9.
- Load = 1, D = 4'd13 -> Q = 9 (clamp). Then En = 1, Up = 0 for 11 edges -> Q = 8..0, 9, 8. TC high while Q = 0.
- En = 0 with Up toggling for 5 edges at Q = 5 -> Q stays 5, J = K = 0, TC = 0, Wrap = 0.
- At Q = 3 counting up, assert Reset for one edge together with Load = 1 -> Q = 0. Counting resumes 1, 2 on the following edges.
- JK_COUNTER_SATURATE_EN defined, Q = 9, Up = 1, En = 1 for 3 edges -> Q stays 9, TC = 1, Wrap = 1 from the second cycle. Up = 0 -> Q = 8.
